aes128_cipher_core: RTL and testbench
=====================================

# aes128_cipher_core

Iterative AES-128 encrypt (cipher) core: the forward-direction counterpart of the decipher core. It turns one 128-bit plaintext block into ciphertext at one round per clock, 11 cycles per block. Round keys come from the external key-expansion block, which is indexed and advanced by this core's `round_num` / `rkey_en` outputs. It sits beside the decipher core and uses the same key schedule.

## Interface
Parameters: none (AES-128, Nr = 10, fixed).

- `clk_sys` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `round_key_0` in 128: initial (cipher) key, used for the round-0 AddRoundKey.
- `round_key` in 128: round key for the current `round_num` (1..10). The key-expansion block supplies it combinationally in the same cycle.
- `plain_text` in 128: input block, sampled only on an accepted `cipher_en`.
- `cipher_en` in 1: start request, one-cycle pulse; honoured only while `cipher_ready` = 1.
- `cipher_text` out 128: result register; holds its value until the next accepted start.
- `cipher_ready` out 1: 1 = idle and able to accept `cipher_en`.
- `cipher_valid` out 1: one-cycle pulse when `cipher_text` holds a new result.
- `round_num` out 4: current round counter, 0..10.
- `rkey_en` out 1: equals ~`cipher_ready`; steps the key-expansion block.

## Operation
**Byte order**
- Follows FIPS-197 column-major order. State byte s[r][c] = bits [127-8(4c+r) -: 8]; column c = bits [127-32c -: 32].

**Datapath**
- One 128-bit state register. Its value drives `cipher_text` directly.

**Start**
- Condition: `cipher_en` = 1 and `cipher_ready` = 1 at a rising edge.
- state ← `plain_text` ^ `round_key_0`.
- `round_num` ← 1.
- `cipher_ready` ← 0.

**Rounds 1..9** (`round_num` = 1..9)
- state ← MixColumns(ShiftRows(SubBytes(state))) ^ `round_key`.
- `round_num` increments by 1.

**Round 10** (`round_num` = 10)
- state ← ShiftRows(SubBytes(state)) ^ `round_key`. MixColumns is bypassed.
- `round_num` ← 0, `cipher_ready` ← 1, `cipher_valid` ← 1 for one cycle.

**Round functions**
- SubBytes: forward S-box, 16 parallel instances.
- ShiftRows: row r rotated left by r bytes.
- MixColumns: per column, matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02] over GF(2^8). xtime uses reduction polynomial 0x11B.

**Counter width**
- 4-bit `round_num` never exceeds 10. Values 11..15 are unreachable; if one is ever seen, force `round_num` to 0 and `cipher_ready` to 1.

**Busy / invalid requests**
- `cipher_en` while busy is ignored. It does not restart the block and does not corrupt the state.

**Reset**
- Reset at any time, including mid-operation, aborts the block immediately.
- Reset values: `cipher_text` = 0, `cipher_ready` = 1, `cipher_valid` = 0, `round_num` = 0, `rkey_en` = 0.

## Timing
**Latency**
- E0 is the edge that accepts `cipher_en`.
- Rounds 1..10 complete at edges E1..E10.
- `cipher_text` becomes final and `cipher_valid` becomes 1 after E10, i.e. 10 cycles after the start edge (11 edges including E0).

**Round key timing**
- `rkey_en` is 1 during the cycles between E0 and E10.
- `round_num` shows 1..10 during those cycles, so `round_key` must be valid in the same cycle that shows the matching `round_num`.

**Next block**
- `cipher_ready` rises after E10. The earliest next `cipher_en` is accepted at E11, giving a throughput of one block per 11 cycles.
- `cipher_en` asserted at E10 (`cipher_ready` still 0) is ignored.

**Intermediate output**
- `cipher_text` shows intermediate round states while busy. Consumers qualify it with `cipher_valid` or `cipher_ready`.

**Combinational path**
- The critical path is S-box → MixColumns → XOR, all within one cycle.

## Test plan
1. **FIPS-197 App. B vector**
   - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
   - Required: after E0 state = 193de3bea0f4e22b9ac68d2ae9f84808; after E10 `cipher_text` = 3925841d02dc09fbdc118597196a0b32, with a single `cipher_valid` pulse.
2. **FIPS-197 App. C.1 vector**
   - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
   - Required: `cipher_text` = 69c4e0d86a7b0430d8cdb78070b4c55a.
   - Required: `round_num` sequence 1..10 then 0; `rkey_en` high for exactly 10 cycles.
3. **Back-to-back starts**
   - Stimulus: vector 1 started at E0, vector 2 started at E11.
   - Required: both results correct; `cipher_ready` low exactly cycles E0..E10 of each block.
4. **Ignored start while busy**
   - Stimulus: assert `cipher_en` with a different pt at round 5 and at E10.
   - Required: result is still 3925841d…0b32; no restart.
5. **Mid-operation reset**
   - Stimulus: assert `rst` at round 6.
   - Required: outputs immediately return to reset values (`cipher_text` 0, `cipher_ready` 1).
   - Required: a following new start with vector 2 yields the correct ciphertext.
6. **Round-trip with decipher core**
   - Stimulus: encrypt 100 random pt/key pairs, then feed each ciphertext to the decipher core with the same key schedule.
   - Required: the recovered plaintext equals the original for every pair.

Source files
------------

// File: rtl/aes128_cipher_core.sv
// aes128_cipher_core
// Iterative AES-128 encryptor. Processes one round per clock and takes 11 cycles per block.
// Round keys come from an external key-expansion block. That block is indexed by
// o_round_num and stepped by o_rkey_en.
//
// Ports
//   i_clk_sys      system clock, rising edge
//   i_rst          asynchronous reset, active high
//   i_round_key_0  cipher key, used for the initial AddRoundKey
//   i_round_key    round key matching o_round_num (1..10), combinational from key expansion
//   i_plain_text   plaintext, sampled only on an accepted start
//   i_cipher_en    start pulse, honoured only while o_cipher_ready = 1
//   o_cipher_text  state register; final once o_cipher_valid pulses
//   o_cipher_ready 1 = idle, start accepted
//   o_cipher_valid one-cycle pulse when a new result is in o_cipher_text
//   o_round_num    current round, 0..10
//   o_rkey_en      ~o_cipher_ready, steps the key-expansion block
//
// state  | meaning
// S_IDLE | waiting for i_cipher_en, round_num = 0
// S_BUSY | running rounds 1..10, one per clock

module aes128_cipher_core (
   input  logic         i_clk_sys,
   input  logic         i_rst,
   input  logic [127:0] i_round_key_0,
   input  logic [127:0] i_round_key,
   input  logic [127:0] i_plain_text,
   input  logic         i_cipher_en,
   output logic [127:0] o_cipher_text,
   output logic         o_cipher_ready,
   output logic         o_cipher_valid,
   output logic [3:0]   o_round_num,
   output logic         o_rkey_en
);

   // Forward S-box. Entry x sits at bits [2047-8x -: 8].
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t       r_fsm, w_fsm_nxt;
   logic [127:0] r_state, w_state_nxt;
   logic [3:0]   r_round, w_round_nxt;
   logic         r_valid, w_valid_nxt;
   logic [127:0] w_sb, w_sr, w_mc;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[11'd2047 - {x, 3'b000} -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
      return o;
   endfunction

   // Byte s[r][c] lives at [127-8(4c+r) -: 8]. Row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = a;
      // 3*x is written as xtime(x) ^ x
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
      return o;
   endfunction

   assign w_sb = sub_bytes(r_state);
   assign w_sr = shift_rows(w_sb);
   assign w_mc = mix_columns(w_sr);

   always_ff @(posedge i_clk_sys or posedge i_rst) begin
      if (i_rst) begin
         r_fsm   <= S_IDLE;
         r_state <= '0;
         r_round <= '0;
         r_valid <= 1'b0;
      end else begin
         r_fsm   <= w_fsm_nxt;
         r_state <= w_state_nxt;
         r_round <= w_round_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_state_nxt = r_state;
      w_round_nxt = 4'd0;
      w_valid_nxt = 1'b0;
      case (r_fsm)
         S_IDLE: begin
            if (i_cipher_en) begin
               w_state_nxt = i_plain_text ^ i_round_key_0;
               w_round_nxt = 4'd1;
               w_fsm_nxt   = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_round == 4'd10) begin
               w_state_nxt = w_sr ^ i_round_key;
               w_valid_nxt = 1'b1;
               w_fsm_nxt   = S_IDLE;
            end else if (r_round >= 4'd1 && r_round <= 4'd9) begin
               w_state_nxt = w_mc ^ i_round_key;
               w_round_nxt = r_round + 4'd1;
            end else begin
               // 0 or 11..15 cannot occur while busy; recover to idle
               w_fsm_nxt = S_IDLE;
            end
         end
         default: w_fsm_nxt = S_IDLE;
      endcase
   end

   assign o_cipher_text  = r_state;
   assign o_cipher_ready = (r_fsm == S_IDLE);
   assign o_rkey_en      = ~o_cipher_ready;
   assign o_cipher_valid = r_valid;
   assign o_round_num    = r_round;

endmodule

// File: tb/tb_aes128_cipher_core.sv
// Bench for aes128_cipher_core. It runs the FIPS-197 vectors, back-to-back starts, starts that
// arrive while the core is busy, and a reset in the middle of a block. It also runs random
// blocks and recovers each plaintext with an independent inverse cipher.
// Round keys come from a key expansion in the bench. Its S-box is derived from the GF(2^8)
// inverse and the affine map.

module tb_aes128_cipher_core;

   logic         clk_sys = 1'b0;
   logic         rst;
   logic [127:0] round_key_0, round_key, plain_text, cipher_text;
   logic         cipher_en, cipher_ready, cipher_valid, rkey_en;
   logic [3:0]   round_num;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [7:0]   sb  [256];
   logic [7:0]   isb [256];
   logic [127:0] rk  [16];

   localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] S10 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   aes128_cipher_core dut (
      .i_clk_sys      (clk_sys),
      .i_rst          (rst),
      .i_round_key_0  (round_key_0),
      .i_round_key    (round_key),
      .i_plain_text   (plain_text),
      .i_cipher_en    (cipher_en),
      .o_cipher_text  (cipher_text),
      .o_cipher_ready (cipher_ready),
      .o_cipher_valid (cipher_valid),
      .o_round_num    (round_num),
      .o_rkey_en      (rkey_en)
   );

   always #5 clk_sys = ~clk_sys;

   // key-expansion stand-in: key for the round the core is showing, same cycle
   always_comb round_key = rk[round_num];

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic init_sbox();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
         end
         b = inv;
         sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                   ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
      for (int i = 0; i < 16; i++) rk[i] = '0;
   endtask

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                              input bit do_mix);
      logic [127:0] o, m;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = isb[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
      o ^= k;
      if (!do_mix) return o;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = o[127-32*c -: 32];
         m[127-32*c -: 32] = {
            gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
      end
      return m;
   endfunction

   function automatic logic [127:0] decrypt(input logic [127:0] ct);
      logic [127:0] s;
      s = ct ^ rk[10];
      for (int r = 9; r >= 1; r--) s = inv_round(s, rk[r], 1'b1);
      return inv_round(s, rk[0], 1'b0);
   endfunction

   // Starts a block at the next edge (E0) and returns just after E10.
   // With inject set, a foreign start is offered while round 5 and round 10 are showing.
   task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] exp, input string tag, input bit inject);
      int n_rkey, n_busy, n_valid;
      n_rkey = 0; n_busy = 0; n_valid = 0;
      expand(key);
      round_key_0 = key;
      plain_text  = pt;
      cipher_en   = 1'b1;
      @(posedge clk_sys); #1;
      cipher_en  = 1'b0;
      plain_text = ~pt;
      check_eq({tag, "_e0_state"}, cipher_text, pt ^ key);
      for (int k = 1; k <= 10; k++) begin
         check_eq($sformatf("%s_round%0d", tag, k), 128'(round_num), 128'(k));
         if (rkey_en) n_rkey++;
         if (!cipher_ready) n_busy++;
         if (cipher_valid) n_valid++;
         if (inject && (k == 5 || k == 10)) begin
            cipher_en  = 1'b1;
            plain_text = 128'hdeadbeef_00000000_cafef00d_12345678;
         end
         @(posedge clk_sys); #1;
         cipher_en = 1'b0;
      end
      check_eq({tag, "_rkey_cycles"}, 128'(n_rkey), 128'd10);
      check_eq({tag, "_busy_cycles"}, 128'(n_busy), 128'd10);
      check_eq({tag, "_early_valid"}, 128'(n_valid), 128'd0);
      check_eq({tag, "_valid"}, 128'(cipher_valid), 128'd1);
      check_eq({tag, "_ready"}, 128'(cipher_ready), 128'd1);
      check_eq({tag, "_round_end"}, 128'(round_num), 128'd0);
      check_eq({tag, "_rkey_end"}, 128'(rkey_en), 128'd0);
      check_eq({tag, "_ct"}, cipher_text, exp);
   endtask

   initial begin
      int guard;
      logic [127:0] key, pt;
      init_sbox();
      rst = 1'b1; cipher_en = 1'b0; plain_text = '0; round_key_0 = '0;
      repeat (2) @(posedge clk_sys);
      #1;
      check_eq("rst_text", cipher_text, 128'd0);
      check_eq("rst_ready", 128'(cipher_ready), 128'd1);
      check_eq("rst_valid", 128'(cipher_valid), 128'd0);
      check_eq("rst_round", 128'(round_num), 128'd0);
      check_eq("rst_rkey", 128'(rkey_en), 128'd0);
      rst = 1'b0;
      @(posedge clk_sys); #1;

      // FIPS-197 App. B; the round-0 state is also checked against the published value
      expand(K1);
      round_key_0 = K1; plain_text = P1; cipher_en = 1'b1;
      @(posedge clk_sys); #1;
      cipher_en = 1'b0;
      check_eq("b_state_after_e0", cipher_text, S10);
      guard = 0;
      while (!cipher_ready && guard < 20) begin
         @(posedge clk_sys); #1;
         guard++;
      end
      check_eq("b_ready_after_block", 128'(cipher_ready), 128'd1);
      run_block(P1, K1, C1, "vecB", 1'b0);
      @(posedge clk_sys); #1;
      check_eq("vecB_valid_drop", 128'(cipher_valid), 128'd0);
      check_eq("vecB_ct_hold", cipher_text, C1);

      // FIPS-197 App. C.1
      run_block(P2, K2, C2, "vecC", 1'b0);

      // back-to-back: second start accepted at E11
      run_block(P1, K1, C1, "b2b_1", 1'b0);
      run_block(P2, K2, C2, "b2b_2", 1'b0);
      @(posedge clk_sys); #1;

      // starts offered while busy, including at E10, must not disturb the block
      run_block(P1, K1, C1, "busy_en", 1'b1);
      @(posedge clk_sys); #1;
      check_eq("busy_en_no_restart", 128'(cipher_ready), 128'd1);
      check_eq("busy_en_ct_hold", cipher_text, C1);

      // reset while round 6 is showing
      expand(K1);
      round_key_0 = K1; plain_text = P1; cipher_en = 1'b1;
      @(posedge clk_sys); #1;
      cipher_en = 1'b0;
      guard = 0;
      while (round_num != 4'd6 && guard < 20) begin
         @(posedge clk_sys); #1;
         guard++;
      end
      check_eq("mid_rst_reached_r6", 128'(round_num), 128'd6);
      #2 rst = 1'b1;
      #1;
      check_eq("mid_rst_text", cipher_text, 128'd0);
      check_eq("mid_rst_ready", 128'(cipher_ready), 128'd1);
      check_eq("mid_rst_round", 128'(round_num), 128'd0);
      check_eq("mid_rst_rkey", 128'(rkey_en), 128'd0);
      check_eq("mid_rst_valid", 128'(cipher_valid), 128'd0);
      @(posedge clk_sys); #1;
      rst = 1'b0;
      @(posedge clk_sys); #1;
      run_block(P2, K2, C2, "after_rst", 1'b0);

      // random blocks, recovered by the inverse cipher
      for (int n = 0; n < 100; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk_sys); #1;
         expand(key);
         round_key_0 = key; plain_text = pt; cipher_en = 1'b1;
         @(posedge clk_sys); #1;
         cipher_en = 1'b0;
         guard = 0;
         while (!cipher_valid && guard < 15) begin
            @(posedge clk_sys); #1;
            guard++;
         end
         if (!cipher_valid) check_eq($sformatf("rt%0d_timeout", n), 128'(cipher_valid), 128'd1);
         else check_eq($sformatf("rt%0d_pt", n), decrypt(cipher_text), pt);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
